// File: rtl/sig_pattern_gen.sv
// Programmable periodic rectangular test-signal generator with double-buffered period/high-time config.
// Optional burst mode: define SIG_PATTERN_GEN_BURST_EN to end a run after burst_i periods.
module sig_pattern_gen #(
  parameter int T_CNT_WIDTH = 32,
  parameter int PCNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   run_i,
  input  logic                   stop_i,
  input  logic [T_CNT_WIDTH-1:0] period_i,
  input  logic [T_CNT_WIDTH-1:0] high_i,
  input  logic [15:0]            burst_i,
  output logic                   sig_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [PCNT_WIDTH-1:0]  period_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HIGH, S_LOW} state_e;

  state_e                 state_q, state_d;
  logic                   run_q;
  logic [T_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [T_CNT_WIDTH-1:0] per_q, per_d;
  logic [T_CNT_WIDTH-1:0] high_q, high_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   sig_q;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [PCNT_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic                   run_det;
  logic                   stop_now;
  logic                   burst_hit;

  function automatic logic cfg_valid(input logic [T_CNT_WIDTH-1:0] p,
                                     input logic [T_CNT_WIDTH-1:0] h);
    return (p >= T_CNT_WIDTH'(2)) && (h != '0) && (h < p);
  endfunction

  assign run_det  = run_i & ~run_q;
  assign stop_now = stop_pend_q | stop_i;

`ifdef SIG_PATTERN_GEN_BURST_EN
  logic [15:0] burst_q, burst_d;
  logic [15:0] bcnt_q, bcnt_d;
  assign burst_hit = (burst_q != 16'd0) && ((bcnt_q + 16'd1) == burst_q);
`else
  logic unused_burst;
  assign unused_burst = ^burst_i;
  assign burst_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    high_d      = high_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    err_d       = err_q;
    pcnt_d      = pcnt_q;
`ifdef SIG_PATTERN_GEN_BURST_EN
    burst_d     = burst_q;
    bcnt_d      = bcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run_det) begin
          per_d       = period_i;
          high_d      = high_i;
          err_d       = 1'b0;
          pcnt_d      = '0;
          stop_pend_d = stop_i;
`ifdef SIG_PATTERN_GEN_BURST_EN
          burst_d     = burst_i;
          bcnt_d      = 16'd0;
`endif
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        stop_pend_d = stop_now;
        if (!cfg_valid(per_q, high_q)) begin
          err_d       = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        stop_pend_d = stop_now;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == high_q - 1'b1) state_d = S_LOW;
      end
      S_LOW: begin
        stop_pend_d = stop_now;
        cnt_d       = cnt_q + 1'b1;
        // Period boundary: reload shadow config and decide whether to continue.
        if (cnt_q == per_q - 1'b1) begin
          pcnt_d = pcnt_q + 1'b1;
          per_d  = period_i;
          high_d = high_i;
          cnt_d  = '0;
`ifdef SIG_PATTERN_GEN_BURST_EN
          bcnt_d = bcnt_q + 16'd1;
`endif
          if (!cfg_valid(period_i, high_i)) begin
            err_d       = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else if (stop_now || burst_hit) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_HIGH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // run_q resets high so a run_i level held through reset is not taken as an edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b1;
      cnt_q       <= '0;
      per_q       <= '0;
      high_q      <= '0;
      stop_pend_q <= 1'b0;
      sig_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pcnt_q      <= '0;
`ifdef SIG_PATTERN_GEN_BURST_EN
      burst_q     <= 16'd0;
      bcnt_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_i;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      high_q      <= high_d;
      stop_pend_q <= stop_pend_d;
      sig_q       <= (state_q == S_HIGH);
      done_q      <= done_d;
      err_q       <= err_d;
      pcnt_q      <= pcnt_d;
`ifdef SIG_PATTERN_GEN_BURST_EN
      burst_q     <= burst_d;
      bcnt_q      <= bcnt_d;
`endif
    end
  end

  assign sig_o        = sig_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign period_cnt_o = pcnt_q;

endmodule

// File: tb/tb_sig_pattern_gen.sv
// Self-checking bench for sig_pattern_gen: per-run waveform timeline model built from period/high lists.
// Burst expectations follow SIG_PATTERN_GEN_BURST_EN when the bench is built with it.
module tb_sig_pattern_gen;
  localparam int TW = 32;
  localparam int PW = 16;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          run_i;
  logic          stop_i;
  logic [TW-1:0] period_i;
  logic [TW-1:0] high_i;
  logic [15:0]   burst_i;
  logic          sig_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [PW-1:0] period_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_p[8];
  int cfg_h[8];

  always #5 clk_i = ~clk_i;

  sig_pattern_gen #(.T_CNT_WIDTH(TW), .PCNT_WIDTH(PW)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .run_i(run_i), .stop_i(stop_i),
    .period_i(period_i), .high_i(high_i), .burst_i(burst_i),
    .sig_o(sig_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .period_cnt_o(period_cnt_o)
  );

  function automatic bit cfg_ok(input int p, input int h);
    return (p >= 2) && (h >= 1) && (h < p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one start..end sequence. stop_m: -1 = stop together with run, else stop_i pulsed
  // at the m-th cycle after the run edge; cfg[n] is the config for period n.
  task automatic do_run(input string name, input int n_cfg, input int stop_m, input int burst);
    bit pat[$];
    int cumq[$];
    int drv[8];
    int tot, e_end, pc, ci, nx;
    bit err_end;
    logic exp_sig;
    tot = 0; err_end = 0;
    foreach (drv[i]) drv[i] = -10;
    if (!cfg_ok(cfg_p[0], cfg_h[0])) begin
      err_end = 1;
      e_end   = 1;
    end else begin
      for (int n = 0; n < 64; n++) begin
        ci = (n < n_cfg) ? n : n_cfg - 1;
        for (int j = 0; j < cfg_p[ci]; j++) pat.push_back(j < cfg_h[ci]);
        tot += cfg_p[ci];
        cumq.push_back(tot);
        nx = (n + 1 < n_cfg) ? n + 1 : n_cfg - 1;
        if (!cfg_ok(cfg_p[nx], cfg_h[nx])) begin err_end = 1; break; end
        if (stop_m <= tot) break;
`ifdef SIG_PATTERN_GEN_BURST_EN
        if (burst != 0 && n + 1 == burst) break;
`endif
      end
      e_end = 1 + tot;
      // config for period n is written somewhere inside period n-1 (after its own sample)
      for (int n = 1; n < n_cfg && n <= cumq.size(); n++) begin
        int lo, hi;
        lo = (n == 1) ? 0 : 1 + cumq[n-2];
        hi = cumq[n-1];
        drv[n] = lo + int'($urandom_range(0, hi - lo));
      end
    end
    @(negedge clk_i);
    period_i = cfg_p[0]; high_i = cfg_h[0]; burst_i = 16'(burst);
    run_i = 1'b1; stop_i = (stop_m == -1);
    for (int m = 0; m <= e_end + 2; m++) begin
      @(negedge clk_i);
      exp_sig = (m >= 2 && m - 2 < pat.size()) ? pat[m-2] : 1'b0;
      pc = 0;
      foreach (cumq[i]) if (cumq[i] <= m - 1) pc++;
      chk({name, ".sig"},  {31'd0, sig_o},  {31'd0, exp_sig});
      chk({name, ".busy"}, {31'd0, busy_o}, {31'd0, m < e_end});
      chk({name, ".done"}, {31'd0, done_o}, {31'd0, (m == e_end) && !err_end});
      chk({name, ".err"},  {31'd0, err_o},  {31'd0, (m >= e_end) && err_end});
      chk({name, ".pcnt"}, {16'd0, period_cnt_o}, 32'(pc));
      $display("run %s m=%0d sig=%b busy=%b done=%b err=%b pcnt=%0d", name, m,
               sig_o, busy_o, done_o, err_o, period_cnt_o);
      run_i = 1'b0;
      stop_i = (m == stop_m);
      if (m == 0) burst_i = 16'($urandom);
      for (int n = 1; n < 8; n++)
        if (drv[n] == m) begin period_i = cfg_p[n]; high_i = cfg_h[n]; end
    end
    stop_i = 1'b0;
  endtask

  task automatic set_cfg(input int i, input int p, input int h);
    cfg_p[i] = p; cfg_h[i] = h;
  endtask

  initial begin
    arst_i = 1'b1; run_i = 1'b0; stop_i = 1'b0;
    period_i = '0; high_i = '0; burst_i = '0;
    #1;
    chk("reset.sig",  {31'd0, sig_o},  32'd0);
    chk("reset.busy", {31'd0, busy_o}, 32'd0);
    chk("reset.done", {31'd0, done_o}, 32'd0);
    chk("reset.err",  {31'd0, err_o},  32'd0);
    chk("reset.pcnt", {16'd0, period_cnt_o}, 32'd0);
    @(negedge clk_i); arst_i = 1'b0;
    @(negedge clk_i);

    // basic 10/3 waveform, stopped after four periods
    set_cfg(0, 10, 3);
    do_run("basic", 1, 35, 0);

    // invalid start configs, then a valid start with simultaneous stop
    set_cfg(0, 10, 0);  do_run("err_h0", 1, 100, 0);
    set_cfg(0, 10, 10); do_run("err_heqp", 1, 100, 0);
    set_cfg(0, 1, 1);   do_run("err_p1", 1, 100, 0);
    set_cfg(0, 2, 1);   do_run("min_stop_with_run", 1, -1, 0);

    // stop during the second high cycle completes the period
    set_cfg(0, 10, 3);  do_run("stop_high", 1, 3, 0);

    // mid-period reconfiguration takes effect only at the boundary
    set_cfg(0, 10, 3); set_cfg(1, 6, 2); do_run("reconf", 2, 12, 0);
    set_cfg(0, 10, 3); set_cfg(1, 6, 6); do_run("reconf_err", 2, 100, 0);

    // burst counts (ignored unless built with the burst feature)
    set_cfg(0, 10, 3); do_run("burst4", 1, 60, 4);
    set_cfg(0, 10, 3); do_run("burst0", 1, 25, 0);

    // async reset in the middle of a high phase
    @(negedge clk_i); period_i = 10; high_i = 3; run_i = 1'b1;
    @(negedge clk_i); run_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("arst.pre_sig", {31'd0, sig_o}, 32'd1);
    #2 arst_i = 1'b1;
    #1;
    chk("arst.sig",  {31'd0, sig_o},  32'd0);
    chk("arst.busy", {31'd0, busy_o}, 32'd0);
    chk("arst.pcnt", {16'd0, period_cnt_o}, 32'd0);
    $display("arst asserted sig=%b busy=%b", sig_o, busy_o);
    run_i = 1'b1;
    @(negedge clk_i); arst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("arst.idle_busy", {31'd0, busy_o}, 32'd0);
      chk("arst.idle_sig",  {31'd0, sig_o},  32'd0);
    end
    run_i = 1'b0;
    @(negedge clk_i);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      int p, h;
      for (int i = 0; i < 8; i++) begin
        p = int'($urandom_range(2, 12));
        h = int'($urandom_range(1, p - 1));
        if (i > 0 && $urandom_range(0, 5) == 0) h = p;
        set_cfg(i, p, h);
      end
      do_run("rand", 4, int'($urandom_range(0, 45)) - 1, int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
